// File: rtl/rr_sel_arbiter4_if.sv
// rr_sel_arbiter4_if: handshake/select bundle between the four requesting
// sources and the round-robin select arbiter.
//   req[3:0]   request per channel (bit k = mux input ik)
//   done       one-cycle release pulse from the granted source
//   sel[1:0]   mux select {S1,S0} = granted channel index
//   grant[3:0] one-hot grant, zero when idle
//   busy       a grant is active
//   timeout    one-cycle pulse when a grant is pre-empted by the hold limit
// master = requester side, slave = arbiter side.
interface rr_sel_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (output req, done, input sel, grant, busy, timeout);
  modport slave  (input req, done, output sel, grant, busy, timeout);
endinterface

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4: round-robin arbiter for four requesters that drives the
// select pair (S0 = sel[0], S1 = sel[1]) of a 4:1 mux built from 2:1 muxes.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   arb  rr_sel_arbiter4_if.slave (req/done in, sel/grant/busy/timeout out)
// Parameter HOLD_MAX (1..255): longest a single grant may be held; only
// meaningful when the macro RR_ARB_TIMEOUT_EN is defined. Without the macro
// a grant is held until done or its request drops, and timeout stays 0.
// All outputs are registered; a new grant always follows one IDLE cycle.
module rr_sel_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_sel_arbiter4_if.slave     arb
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_sel_arbiter4: HOLD_MAX must be 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] sel_q;
  logic [3:0] grant_q;
  logic       busy_q;

  // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4). Walking offsets from high to
  // low lets the smallest offset overwrite, so the first hit wins.
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (arb.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Normal release causes; any combination counts as one release.
  logic rel_norm;
  assign rel_norm = arb.done | ~arb.req[sel_q];

  logic hold_exp;
`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0] cnt_q;
  logic       timeout_q;
  assign hold_exp    = (cnt_q == HOLD_LIM);
  assign arb.timeout = timeout_q;
`else
  assign hold_exp    = 1'b0;
  assign arb.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      grant_q   <= 4'd0;
      busy_q    <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // sel is left alone when nobody requests so Y stays stable
          if (pick_vld) begin
            grant_q <= 4'b0001 << pick_idx;
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= 8'd1;
`endif
          end
        end
        GRANT: begin
          if (rel_norm || hold_exp) begin
            grant_q <= 4'd0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + 2'd1;
            state_q <= IDLE;
`ifdef RR_ARB_TIMEOUT_EN
            // only a pure hold-limit release is reported as a timeout
            timeout_q <= ~rel_norm;
`endif
          end else begin
`ifdef RR_ARB_TIMEOUT_EN
            if (cnt_q != HOLD_LIM) cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.sel   = sel_q;
  assign arb.grant = grant_q;
  assign arb.busy  = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
module tb_rr_sel_arbiter4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_sel_arbiter4_if bus ();
  rr_sel_arbiter4 #(.HOLD_MAX(3)) dut (.clk(clk), .rst(rst), .arb(bus));

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       to;
    logic       y;
    string      nm;
  } exp_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
  } gexp_t;

  exp_t  exp_q[$];
  gexp_t gnt_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [3:0] ivals = 4'b1010;  // i3..i0 = 1,0,1,0
  logic [3:0] prev_g = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With i0..i3 = 0,1,0,1 the mux output simply follows S0.
  task automatic expect_st(int n, logic [1:0] s, logic [3:0] g, logic b, logic t, string nm);
    exp_t e;
    e.cyc = cyc + n; e.sel = s; e.grant = g; e.busy = b; e.to = t; e.y = s[0]; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic push_g(logic [3:0] g, logic [1:0] s);
    gexp_t e;
    e.grant = g; e.sel = s;
    gnt_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    logic y_act;
    logic [1:0] gidx;
    exp_t e;
    gexp_t ge;
    y_act = bus.sel[1] ? (bus.sel[0] ? ivals[3] : ivals[2])
                       : (bus.sel[0] ? ivals[1] : ivals[0]);
    if (cyc >= 1) begin
      gidx = 2'd0;
      for (int i = 0; i < 4; i++) if (bus.grant[i]) gidx = 2'(i);
      n_cmp++;
      if (!$onehot0(bus.grant) || bus.busy !== (|bus.grant) ||
          (bus.busy && bus.sel !== gidx)) begin
        n_bad++;
        $display("FAIL invariant cyc %0d: got grant=%b busy=%b sel=%b", cyc, bus.grant, bus.busy, bus.sel);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || bus.sel !== e.sel || bus.grant !== e.grant ||
          bus.busy !== e.busy || bus.timeout !== e.to || y_act !== e.y) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got sel=%b grant=%b busy=%b to=%b y=%b, want sel=%b grant=%b busy=%b to=%b y=%b",
                 e.nm, cyc, bus.sel, bus.grant, bus.busy, bus.timeout, y_act,
                 e.sel, e.grant, e.busy, e.to, e.y);
      end
    end
    if (cyc >= 1 && bus.grant !== 4'd0 && prev_g === 4'd0) begin
      n_cmp++;
      if (gnt_q.size() == 0) begin
        n_bad++;
        $display("FAIL grant_order cyc %0d: got grant=%b, want no new grant", cyc, bus.grant);
      end else begin
        ge = gnt_q.pop_front();
        if (bus.grant !== ge.grant || bus.sel !== ge.sel) begin
          n_bad++;
          $display("FAIL grant_order cyc %0d: got grant=%b sel=%b, want grant=%b sel=%b",
                   cyc, bus.grant, bus.sel, ge.grant, ge.sel);
        end
      end
    end
    prev_g <= bus.grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] ch;
    logic [3:0] oh;
    int budget;
    rst = 1'b1; bus.req = 4'b1111; bus.done = 1'b0;

    // Reset held two edges with everyone requesting
    expect_st(1, 2'b00, 4'b0000, 1'b0, 1'b0, "reset1");
    expect_st(2, 2'b00, 4'b0000, 1'b0, 1'b0, "reset2");
    tick(); tick();
    rst = 1'b0;

    // Round-robin: 0,1,2,3,0, done two cycles after each grant
    for (int k = 0; k < 5; k++) begin
      ch = 2'(k);
      oh = 4'b0001 << ch;
      push_g(oh, ch);
      expect_st(1, ch, oh, 1'b1, 1'b0, "rr_grant");
      tick();
      expect_st(1, ch, oh, 1'b1, 1'b0, "rr_hold");
      tick();
      bus.done = 1'b1;
      expect_st(1, ch, 4'b0000, 1'b0, 1'b0, "rr_release");
      tick();
      bus.done = 1'b0;
    end

    // Single requester on channel 2 (ptr=1): Y must read i2 = 0
    bus.req = 4'b0100;
    push_g(4'b0100, 2'b10);
    expect_st(1, 2'b10, 4'b0100, 1'b1, 1'b0, "single_grant");
    tick();
    bus.done = 1'b1;
    expect_st(1, 2'b10, 4'b0000, 1'b0, 1'b0, "single_done");
    tick();
    bus.done = 1'b0;
    bus.req = 4'b0000;
    expect_st(1, 2'b10, 4'b0000, 1'b0, 1'b0, "idle_sel_hold");
    tick();
    // done while idle changes nothing
    bus.done = 1'b1;
    expect_st(1, 2'b10, 4'b0000, 1'b0, 1'b0, "idle_done_ignored");
    tick();
    bus.done = 1'b0;

    // Skip and wrap: ptr=3, only channels 0/1 request -> channel 0
    bus.req = 4'b0011;
    push_g(4'b0001, 2'b00);
    expect_st(1, 2'b00, 4'b0001, 1'b1, 1'b0, "wrap_grant");
    tick();
    bus.done = 1'b1; bus.req = 4'b0010;
    expect_st(1, 2'b00, 4'b0000, 1'b0, 1'b0, "wrap_release");
    tick();
    bus.done = 1'b0;

    // Channel 1 granted, then its request drops -> ptr=2
    push_g(4'b0010, 2'b01);
    expect_st(1, 2'b01, 4'b0010, 1'b1, 1'b0, "ch1_grant");
    tick();
    bus.req = 4'b1100;
    expect_st(1, 2'b01, 4'b0000, 1'b0, 1'b0, "req_drop_release");
    tick();
    // ptr=2 check: channel 1 requesting but 2 must win
    bus.req = 4'b1110;
    push_g(4'b0100, 2'b10);
    expect_st(1, 2'b10, 4'b0100, 1'b1, 1'b0, "ptr2_grant");
    tick();
    bus.req = 4'b1010;
    expect_st(1, 2'b10, 4'b0000, 1'b0, 1'b0, "ch2_drop");
    tick();
    // ptr=3: only channel 1 -> re-grant 1, then reset mid-grant
    bus.req = 4'b0010;
    push_g(4'b0010, 2'b01);
    expect_st(1, 2'b01, 4'b0010, 1'b1, 1'b0, "ch1_regrant");
    tick();
    rst = 1'b1; bus.req = 4'b1111;
    expect_st(1, 2'b00, 4'b0000, 1'b0, 1'b0, "mid_grant_reset");
    tick();
    rst = 1'b0;
    push_g(4'b0001, 2'b00);
    expect_st(1, 2'b00, 4'b0001, 1'b1, 1'b0, "post_reset_ptr0");
    tick();
    bus.done = 1'b1; bus.req = 4'b0001;
    expect_st(1, 2'b00, 4'b0000, 1'b0, 1'b0, "post_reset_release");
    tick();
    bus.done = 1'b0;

    // Hold-limit behaviour, channel 0 alone, no done
    push_g(4'b0001, 2'b00);
    expect_st(1, 2'b00, 4'b0001, 1'b1, 1'b0, "hold_grant");
    tick();
`ifdef RR_ARB_TIMEOUT_EN
    expect_st(1, 2'b00, 4'b0001, 1'b1, 1'b0, "hold_c2");
    expect_st(2, 2'b00, 4'b0001, 1'b1, 1'b0, "hold_c3");
    expect_st(3, 2'b00, 4'b0000, 1'b0, 1'b1, "timeout_pulse");
    expect_st(4, 2'b00, 4'b0001, 1'b1, 1'b0, "timeout_regrant");
    push_g(4'b0001, 2'b00);
    tick(); tick(); tick(); tick();
    expect_st(1, 2'b00, 4'b0001, 1'b1, 1'b0, "tdone_c2");
    expect_st(2, 2'b00, 4'b0001, 1'b1, 1'b0, "tdone_c3");
    tick(); tick();
    bus.done = 1'b1;
    expect_st(1, 2'b00, 4'b0000, 1'b0, 1'b0, "done_at_limit_no_timeout");
    tick();
    bus.done = 1'b0;
`else
    expect_st(5, 2'b00, 4'b0001, 1'b1, 1'b0, "no_timeout_5");
    expect_st(20, 2'b00, 4'b0001, 1'b1, 1'b0, "no_timeout_20");
    repeat (20) tick();
    bus.done = 1'b1;
    expect_st(1, 2'b00, 4'b0000, 1'b0, 1'b0, "long_hold_release");
    tick();
    bus.done = 1'b0;
`endif
    bus.req = 4'b0000;
    tick();

    budget = 0;
    while (exp_q.size() > 0 && budget < 30) begin tick(); budget++; end
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expectations pending, want 0", exp_q.size());
    end
    n_cmp++;
    if (gnt_q.size() != 0) begin
      n_bad++;
      $display("FAIL grant_drain: got %0d grants never seen, want 0", gnt_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_sel_arbiter4.md
Name: rr_sel_arbiter4

Overview:
- Round-robin arbiter for four requesters.
- Drives the 2-bit select pair (S0, S1) of the 4:1 mux built from three 2:1 muxes, so the granted source's data reaches the mux output Y.
- Sits directly upstream of the mux. It replaces the hand-driven select stimulus with clocked, fair, handshaked channel selection.
- One-hot grant tells each source when its data is on Y.

Parameters:
- HOLD_MAX, 8: max consecutive cycles one grant may be held. Used only when RR_ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  request per channel; bit k = mux input ik
- done  in  1  one-cycle release pulse from the currently granted source
- sel  out  2  mux select: sel[0] = S0 (first-level mux select), sel[1] = S1 (final mux select); value = granted channel index
- grant  out  4  one-hot grant; all zero when idle
- busy  out  1  high while a grant is active
- timeout  out  1  one-cycle pulse when a grant is pre-empted (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset, sampled on the clk edge while rst=1:
  - sel=2'b00, grant=4'b0000, busy=0, timeout=0
  - internal pointer ptr=0, hold counter cnt=0, state=IDLE
  - rst overrides everything, including mid-grant; the grant drops on the very next edge.
- State IDLE:
  - If req==0, stay in IDLE; sel holds its last value so the mux output stays stable.
  - Otherwise, search from ptr upward modulo 4 (ptr, ptr+1, ptr+2, ptr+3) and take the first index k with req[k]=1.
  - At the next edge: grant=1<<k, sel=k, busy=1, cnt=1, state=GRANT.
  - Latency: req sampled at edge N gives grant visible after edge N.
- State GRANT:
  - Release when any of these holds at an edge: done=1, req[sel]=0, or the timeout condition.
  - On release: grant=0, busy=0, ptr=(sel+1) mod 4 with 2-bit wrap so 3 becomes 0, state=IDLE. sel keeps its value.
  - Otherwise grant holds and cnt increments, saturating at HOLD_MAX.
- Simultaneous release causes are a single release: one pointer advance, not two.
- A new grant always needs one IDLE cycle, so there are no back-to-back grants. Minimum gap between grants is 1 cycle.
- done in IDLE is ignored.
- req changes on non-granted channels during GRANT are ignored until the next arbitration.
- Fairness: with all four requesting continuously and releasing via done, the grant order is 0,1,2,3,0,...
- Invariants:
  - grant is zero or one-hot.
  - busy == |grant.
  - When busy=1, sel == index of grant.

Optional Feature:
- Macro RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when cnt==HOLD_MAX and no other release cause is present, the grant is released at that edge and timeout pulses 1 for exactly one cycle.
  - The grant is therefore high for exactly HOLD_MAX cycles.
  - Pointer advance is the same as for a normal release.
  - If done or a req drop coincides with cnt==HOLD_MAX, it is a normal release and timeout stays 0.
- Undefined:
  - No counter logic.
  - A grant is held indefinitely until done or req drop.
  - timeout is tied to 0.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles with req=4'b1111.
  - Required: sel=00, grant=0000, busy=0, timeout=0. Deassert rst and grant=0001 appears after 1 edge.
- Single requester:
  - Stimulus: req=4'b0100, with i0..i3 = 0,1,0,1 driving the 4:1 mux.
  - Required: after 1 edge, grant=0100, sel=10, mux Y=0.
  - Then: pulse done. Required: grant=0000, busy=0, sel stays 10.
- Round-robin rotation:
  - Stimulus: req=4'b1111, pulse done 2 cycles after each grant.
  - Required: grant sequence 0001,0010,0100,1000,0001, with sel 00,01,10,11,00 and one idle cycle between grants.
- Skip and wrap:
  - Stimulus: ptr=3 (after releasing channel 2), req=4'b0011.
  - Required: grant=0001 (wrap 3→0, channel 3 not requesting), sel=00.
- Req drop and mid-grant reset:
  - Stimulus: channel 1 granted, drop req[1].
  - Required: release next edge, ptr=2.
  - Stimulus: re-grant channel 1, then assert rst.
  - Required: grant=0000, ptr=0 next edge.
- Timeout (macro defined, HOLD_MAX=3):
  - Stimulus: req=4'b0001 held, no done.
  - Required: grant high for exactly 3 cycles, timeout=1 for 1 cycle at the release edge, re-grant 0001 after 1 idle cycle.
  - Stimulus: done coinciding with cnt==3.
  - Required: timeout=0.
  - Macro undefined: grant is still high after 20 cycles and timeout stays 0.
